// File: rtl/hack_pkg.sv
// hack_pkg -- shared constants for the Hack CPU core, the ROM tooling and the
// disassembler.
//   DATA_W / ADDR_W : data/instruction width and ROM/RAM address width. The ISA
//                     fixes both values, so do not override them.
//   *_BIT, COMP_*, DEST_*, J* : bit positions of the fields in an instruction word.
//   jump_taken()    : evaluates the jump condition from the j field and the
//                     ALU flags.
package hack_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 15;

   localparam int INSTR_TYPE_BIT = 15;  // 0 = A-instruction, 1 = C-instruction
   localparam int A_BIT          = 12;  // ALU y operand: 0 = A, 1 = inM
   localparam int COMP_MSB       = 11;  // comp field: zx,nx,zy,ny,f,no
   localparam int COMP_LSB       = 6;
   localparam int DEST_A         = 5;
   localparam int DEST_D         = 4;
   localparam int DEST_M         = 3;
   localparam int JLT            = 2;
   localparam int JEQ            = 1;
   localparam int JGT            = 0;

   // comp field bit positions, relative to the 6-bit comp field
   localparam int C_ZX = 5;
   localparam int C_NX = 4;
   localparam int C_ZY = 3;
   localparam int C_NY = 2;
   localparam int C_F  = 1;
   localparam int C_NO = 0;

   // The "greater than" leg is the case that is neither negative nor zero.
   function automatic logic jump_taken(input logic [2:0] j,
                                       input logic       zr,
                                       input logic       ng);
      return (j[JLT] & ng) | (j[JEQ] & zr) | (j[JGT] & ~ng & ~zr);
   endfunction

endpackage

// File: rtl/hack_cpu_if.sv
// hack_cpu_if -- groups the program-ROM and data-RAM bus of the Hack core.
//   pc          : program-ROM address. The core drives it.
//   instruction : ROM word at pc. The ROM drives it.
//   addressM    : data-RAM address, equal to A[14:0].
//   outM        : data-RAM write data, which is the ALU result.
//   writeM      : data-RAM write strobe.
//   inM         : data-RAM read data at addressM. It must be combinational.
// Bus semantics: there is no valid/ready pair and no backpressure. The ROM and
// RAM must answer within the same cycle. A RAM write happens at the rising edge
// of any cycle in which writeM is high. The only way to hold the core is the
// cpu_en input on the core itself.
//   modport master : CPU side.
//   modport slave  : ROM/RAM side.
interface hack_cpu_if;
   import hack_pkg::*;

   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] instruction;
   logic [ADDR_W-1:0] addressM;
   logic [DATA_W-1:0] outM;
   logic              writeM;
   logic [DATA_W-1:0] inM;

   modport master (
      output pc, addressM, outM, writeM,
      input  instruction, inM
   );

   modport slave (
      input  pc, addressM, outM, writeM,
      output instruction, inM
   );

endinterface

// File: rtl/hack_alu.sv
// hack_alu -- the Hack ALU. It is purely combinational.
//   x, y : operands. The core wires x to D and y to A or inM.
//   c    : comp control bits {zx,nx,zy,ny,f,no}.
//   out  : result.
//   zr   : out == 0.
//   ng   : out is negative (out[15] is set).
module hack_alu
   import hack_pkg::*;
(
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   input  logic [5:0]        c,
   output logic [DATA_W-1:0] out,
   output logic              zr,
   output logic              ng
);

   logic [DATA_W-1:0] xz, xn, yz, yn, res;

   always_comb begin
      xz  = c[C_ZX] ? '0 : x;
      xn  = c[C_NX] ? ~xz : xz;
      yz  = c[C_ZY] ? '0 : y;
      yn  = c[C_NY] ? ~yz : yz;
      // The add wraps at 16 bits, so the carry out is dropped on purpose.
      res = c[C_F] ? (xn + yn) : (xn & yn);
      out = c[C_NO] ? ~res : res;
      zr  = (out == '0);
      ng  = out[DATA_W-1];
   end

endmodule

// File: rtl/hack_cpu.sv
// hack_cpu -- single-cycle Hack CPU core. It holds the A, D and PC registers
// and commits one instruction per rising clock edge.
//   clk    : rising-edge clock.
//   rst_n  : asynchronous active-low reset. It clears A, D and PC (and halted)
//            and gates writeM.
//   cpu_en : execute enable. When it is low, A, D and PC hold and writeM is 0.
//   bus    : hack_cpu_if.master, which carries pc/instruction and
//            addressM/outM/writeM/inM.
//   halted : sticky halt-loop flag. It exists only when HACK_HALT_DETECT_EN
//            is defined.
// Optional feature macro: HACK_HALT_DETECT_EN.
module hack_cpu
   import hack_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_en,
   hack_cpu_if.master  bus
`ifdef HACK_HALT_DETECT_EN
   ,
   output logic        halted
`endif
);

   logic [DATA_W-1:0] a_q, d_q;
   logic [ADDR_W-1:0] pc_q;

   logic [DATA_W-1:0] instr;
   logic              is_c;
   logic [DATA_W-1:0] alu_y;
   logic [DATA_W-1:0] alu_out;
   logic              alu_zr, alu_ng;
   logic              take;
   logic [DATA_W-1:0] a_next, d_next;
   logic [ADDR_W-1:0] pc_next;

   assign instr = bus.instruction;
   assign is_c  = instr[INSTR_TYPE_BIT];
   assign alu_y = instr[A_BIT] ? bus.inM : a_q;

   // The ALU always decodes the current word, even for A-instructions. This
   // keeps outM a pure function of the state and the inputs.
   hack_alu u_alu (
      .x   (d_q),
      .y   (alu_y),
      .c   (instr[COMP_MSB:COMP_LSB]),
      .out (alu_out),
      .zr  (alu_zr),
      .ng  (alu_ng)
   );

   assign take = is_c & jump_taken(instr[JLT:JGT], alu_zr, alu_ng);

   always_comb begin
      a_next  = a_q;
      d_next  = d_q;
      // The jump target is the A value before any update this cycle. The
      // increment wraps 0x7FFF to 0x0000.
      pc_next = take ? a_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
      if (!is_c) begin
         a_next = {1'b0, instr[ADDR_W-1:0]};
      end else begin
         if (instr[DEST_A]) a_next = alu_out;
         if (instr[DEST_D]) d_next = alu_out;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q  <= '0;
         d_q  <= '0;
         pc_q <= '0;
      end else if (cpu_en) begin
         a_q  <= a_next;
         d_q  <= d_next;
         pc_q <= pc_next;
      end
   end

   assign bus.pc       = pc_q;
   // The M write uses the A value from before the edge. For "AM=..." the
   // store therefore goes to the old address.
   assign bus.addressM = a_q[ADDR_W-1:0];
   assign bus.outM     = alu_out;
   // rst_n is part of the gate, so a store cannot leak out while reset is held.
   assign bus.writeM   = is_c & instr[DEST_M] & cpu_en & rst_n;

`ifdef HACK_HALT_DETECT_EN
   logic halted_q;
   logic halt_hit;

   // The jump lands on this instruction (pc) or on the one before it (pc-1).
   // The second case is the "@END; 0;JMP" idiom. The core keeps running and
   // only the flag is recorded.
   assign halt_hit = take &&
                     ((a_q[ADDR_W-1:0] == pc_q) ||
                      (a_q[ADDR_W-1:0] == pc_q - ADDR_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted_q <= 1'b0;
      end else if (cpu_en && halt_hit) begin
         halted_q <= 1'b1;
      end
   end

   assign halted = halted_q;
`endif

endmodule

// File: tb/tb_hack_cpu.sv
// tb_hack_cpu -- self-checking bench for hack_cpu.
// The bench acts as the program ROM and the data RAM. A reference model in
// this file computes the expected pc, bus outputs, A and D for every cycle.
// A and D are read through the bus with probe words: the word for "D" puts D
// on outM, and the word for "A" puts A on outM. The clock does not tick
// during a probe, so nothing is committed.
module tb_hack_cpu;
   import hack_pkg::*;

   logic clk    = 1'b0;
   logic rst_n  = 1'b1;
   logic cpu_en = 1'b0;
`ifdef HACK_HALT_DETECT_EN
   logic halted;
`endif

   hack_cpu_if bus ();

   logic [15:0] rom [0:32767];
   logic [15:0] ram [0:32767];

   assign bus.inM = ram[bus.addressM];

   hack_cpu dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .cpu_en (cpu_en),
      .bus    (bus)
`ifdef HACK_HALT_DETECT_EN
      ,
      .halted (halted)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [15:0] m_a, m_d;
   logic [14:0] m_pc;
   logic        m_halt;

   // DUT outputs sampled in the most recent cycle
   logic        obs_write;
   logic [14:0] obs_addr;
   logic [15:0] obs_out;

   function automatic logic [15:0] ref_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
      logic [15:0] xx, yy, r;
      xx = c[5] ? 16'd0 : x;
      if (c[4]) xx = ~xx;
      yy = c[3] ? 16'd0 : y;
      if (c[2]) yy = ~yy;
      r = c[1] ? xx + yy : xx & yy;
      return c[0] ? ~r : r;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_a = 16'd0; m_d = 16'd0; m_pc = 15'd0; m_halt = 1'b0;
   endtask

   task automatic probe(output logic [15:0] pa, output logic [15:0] pd);
      logic [15:0] saved;
      saved = bus.instruction;
      bus.instruction = 16'hE300;  // D
      #1 pd = bus.outM;
      bus.instruction = 16'hEC00;  // A
      #1 pa = bus.outM;
      bus.instruction = saved;
   endtask

   // Runs one cycle. Inputs change on the falling edge and outputs are checked
   // before the rising edge. The model commits just after the rising edge.
   task automatic run_cycle(input logic en);
      logic [15:0] ins, yv, o, pa, pd;
      logic        is_c, tk;
      @(negedge clk);
      cpu_en = en;
      probe(pa, pd);
      check("a_reg", pa, m_a);
      check("d_reg", pd, m_d);
      bus.instruction = rom[bus.pc];
      #1;
      ins  = rom[m_pc];
      is_c = ins[15];
      yv   = ins[12] ? ram[m_a[14:0]] : m_a;
      o    = ref_alu(m_d, yv, ins[11:6]);
      tk   = is_c && ((ins[2] && $signed(o) < 0) || (ins[1] && o == 16'd0) ||
                      (ins[0] && $signed(o) > 0));
      obs_write = bus.writeM;
      obs_addr  = bus.addressM;
      obs_out   = bus.outM;
      check("pc", 16'(bus.pc), 16'(m_pc));
      check("writeM", 16'(obs_write), 16'(is_c && ins[3] && en));
      check("addressM", 16'(obs_addr), 16'(m_a[14:0]));
      check("outM", obs_out, o);
`ifdef HACK_HALT_DETECT_EN
      check("halted", 16'(halted), 16'(m_halt));
`endif
      @(posedge clk);
      #1;
      if (en) begin
         if (is_c && ins[3]) ram[m_a[14:0]] = o;
         if (tk && (m_a[14:0] == m_pc || m_a[14:0] == m_pc - 15'd1)) m_halt = 1'b1;
         m_pc = tk ? m_a[14:0] : m_pc + 15'd1;
         if (!is_c) m_a = {1'b0, ins[14:0]};
         else begin
            if (ins[5]) m_a = o;
            if (ins[4]) m_d = o;
         end
      end
   endtask

   // Reset is asserted between edges. A, D and PC must clear at once, and
   // writeM must stay low even with an "M=D" word on the bus.
   task automatic do_reset();
      logic [15:0] pa, pd;
      cpu_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      model_reset();
      probe(pa, pd);
      check("rst_a", pa, 16'd0);
      check("rst_d", pd, 16'd0);
      check("rst_pc", 16'(bus.pc), 16'd0);
      bus.instruction = 16'hE308;
      cpu_en = 1'b1;
      #1;
      check("rst_writeM", 16'(bus.writeM), 16'd0);
      check("rst_outM", bus.outM, 16'd0);
`ifdef HACK_HALT_DETECT_EN
      check("rst_halted", 16'(halted), 16'd0);
`endif
      cpu_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [15:0] pa, pd;
      bus.instruction = 16'h0000;
      for (int i = 0; i < 32768; i++) begin
         rom[i] = 16'($urandom);
         ram[i] = 16'($urandom);
      end

      // Program 1: @2, D=A, @3, D=D+A, @0, M=D
      rom[0] = 16'h0002; rom[1] = 16'hEC10; rom[2] = 16'h0003;
      rom[3] = 16'hE090; rom[4] = 16'h0000; rom[5] = 16'hE308;
      do_reset();
      for (int i = 0; i < 4; i++) run_cycle(1'b1);
      probe(pa, pd);
      check("p1_d_after3", pd, 16'd5);
      run_cycle(1'b1);
      run_cycle(1'b1);
      check("p1_writeM", 16'(obs_write), 16'd1);
      check("p1_addressM", 16'(obs_addr), 16'd0);
      check("p1_outM", obs_out, 16'h0005);
      check("p1_pc6", 16'(bus.pc), 16'd6);

      // Stall: hold the core on the "M=D" word for three cycles, then resume.
      do_reset();
      for (int i = 0; i < 5; i++) run_cycle(1'b1);
      for (int i = 0; i < 3; i++) begin
         run_cycle(1'b0);
         check("stall_writeM", 16'(obs_write), 16'd0);
         check("stall_pc", 16'(bus.pc), 16'd5);
      end
      run_cycle(1'b1);
      check("resume_writeM", 16'(obs_write), 16'd1);
      check("resume_pc", 16'(bus.pc), 16'd6);

      // Asynchronous reset after four instructions
      do_reset();
      for (int i = 0; i < 4; i++) run_cycle(1'b1);
      #2;
      do_reset();
      run_cycle(1'b1);
      check("post_rst_a", 16'(obs_addr), 16'd0);
      check("post_rst_pc", 16'(bus.pc), 16'd1);

      // Program 2: @5, D=A, @10, D;JGT -- the jump is taken
      rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h000A; rom[3] = 16'hE301;
      do_reset();
      for (int i = 0; i < 4; i++) run_cycle(1'b1);
      check("jgt_taken_pc", 16'(bus.pc), 16'd10);

      // Program 2b: @0, D=A-1, @10, D;JGT -- the jump is not taken
      rom[0] = 16'h0000; rom[1] = 16'hEC90;
      do_reset();
      for (int i = 0; i < 4; i++) run_cycle(1'b1);
      check("jgt_not_taken_pc", 16'(bus.pc), 16'd4);

      // AM=M+1 at A=0x0010 with M=0x7FFF
      rom[0] = 16'h0010; rom[1] = 16'hFDE8;
      ram[16] = 16'h7FFF;
      do_reset();
      run_cycle(1'b1);
      run_cycle(1'b1);
      check("am_writeM", 16'(obs_write), 16'd1);
      check("am_addressM", 16'(obs_addr), 16'h0010);
      check("am_outM", obs_out, 16'h8000);
      check("am_ng", 16'(obs_out[15]), 16'd1);
      probe(pa, pd);
      check("am_new_a", pa, 16'h8000);

      // PC wrap: jump to 0x7FFF, then an A-instruction steps PC to 0
      rom[0] = 16'h7FFF; rom[1] = 16'hEA87; rom[32767] = 16'h0000;
      do_reset();
      for (int i = 0; i < 3; i++) run_cycle(1'b1);
      check("pc_wrap", 16'(bus.pc), 16'd0);

`ifdef HACK_HALT_DETECT_EN
      // Halt idiom: @4 at address 4, 0;JMP at address 5
      rom[0] = 16'h0000; rom[1] = 16'h0000; rom[2] = 16'h0000;
      rom[3] = 16'h0003; rom[4] = 16'h0004; rom[5] = 16'hEA87;
      do_reset();
      for (int i = 0; i < 6; i++) run_cycle(1'b1);
      check("halt_set", 16'(halted), 16'd1);
      check("halt_pc", 16'(bus.pc), 16'd4);
      for (int i = 0; i < 4; i++) run_cycle(1'b1);
      check("halt_sticky", 16'(halted), 16'd1);
      do_reset();
      check("halt_cleared", 16'(halted), 16'd0);
`endif

      // Random programs, random RAM, random stalls
      for (int i = 0; i < 32768; i++) begin
         rom[i] = 16'($urandom);
         ram[i] = 16'($urandom);
      end
      do_reset();
      for (int i = 0; i < 1500; i++) run_cycle(1'($urandom_range(0, 9) != 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
